// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder processes a+b+cin LSB first, one bit per clock.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port selecting a-b (as a + ~b + 1).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_count;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_bLoad;
    logic             w_cLoad;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction reuses the adder: invert b and force the initial carry to 1.
    assign w_bLoad = sub ? ~b : b;
    assign w_cLoad = sub ? 1'b1 : cin;
`else
    assign w_bLoad = b;
    assign w_cLoad = cin;
`endif

    assign w_last   = (r_count == CW'(WIDTH - 1));
    assign w_accept = (r_state == IDLE) && start;

    FullAdder u_fa (
        .i_a     (r_a[0]),
        .i_b     (r_b[0]),
        .i_carry (r_carry),
        .o_sum   (w_s),
        .o_carry (w_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Result bits enter from the MSB side so the last shift leaves them aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_bLoad;
            r_carry <= w_cLoad;
            r_res   <= '0;
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_c;
            r_res   <= {w_s, r_res[WIDTH-1:1]};
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_sum  <= {w_s, r_res[WIDTH-1:1]};
                r_cout <= w_c;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// 1-bit full adder shared by the serial datapath.
module FullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b ^ i_carry;
    assign o_carry = (i_a & i_b) | (i_a & i_carry) | (i_b & i_carry);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with hand-computed results.
// Define SERIAL_ADD_SUB_EN to also exercise the subtract mode.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int         vecCount  = 0;
    int         missCount = 0;
    logic [7:0] prevSum   = 8'h00;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE; optionally injects a stray start mid-run.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_, input logic tcin,
                                 input logic tsub, input logic disturb,
                                 input logic [7:0] expSum, input logic expCout);
        a     = ta;
        b     = tb_;
        cin   = tcin;
        sub   = tsub;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("busyRun", {31'd0, busy}, 32'd1);
            checkOutput("doneRun", {31'd0, done}, 32'd0);
            checkOutput("sumHold", {24'd0, sum}, {24'd0, prevSum});
            if (disturb && i == 2) begin
                start = 1'b1;
                a     = 8'h00;
                b     = 8'h00;
                cin   = 1'b1;
                sub   = ~tsub;
            end
            if (i == 3) start = 1'b0;
            if (i < 7) tick();
        end
        tick();
        checkOutput("doneHigh", {31'd0, done}, 32'd1);
        checkOutput("busyDone", {31'd0, busy}, 32'd0);
        checkOutput("sum", {24'd0, sum}, {24'd0, expSum});
        checkOutput("cout", {31'd0, cout}, {31'd0, expCout});
        tick();
        checkOutput("donePulse", {31'd0, done}, 32'd0);
        checkOutput("busyIdle", {31'd0, busy}, 32'd0);
        checkOutput("sumKeep", {24'd0, sum}, {24'd0, expSum});
        prevSum = expSum;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        sub   = 1'b0;
        tick();
        tick();
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        checkOutput("rstSum", {24'd0, sum}, 32'd0);
        checkOutput("rstCout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1);
        applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0);
        applyStimulus(8'h5A, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
        applyStimulus(8'h35, 8'h4A, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("noExtraDone", {31'd0, done}, 32'd0);
        end

        // Abort with reset at edge k+4; sum is 7F beforehand so the clear is visible.
        a     = 8'h35;
        b     = 8'h4A;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        checkOutput("abortSum", {24'd0, sum}, 32'd0);
        checkOutput("abortCout", {31'd0, cout}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("abortNoDone", {31'd0, done}, 32'd0);
            checkOutput("abortNoBusy", {31'd0, busy}, 32'd0);
        end
        prevSum = 8'h00;
        applyStimulus(8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 8'h47, 1'b0);

        // Reset and start together: reset wins.
        a     = 8'h01;
        b     = 8'h01;
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rstStartBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstStartSum", {24'd0, sum}, 32'd0);
        tick();
        checkOutput("rstStartIdle", {31'd0, busy}, 32'd0);
        prevSum = 8'h00;

`ifdef SERIAL_ADD_SUB_EN
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b1);
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
        applyStimulus(8'h40, 8'h40, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        applyStimulus(8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 8'h04, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
